// File: rtl/cache_miss_ctrl_if.sv
// Bundle between the D-cache miss controller, the CPU port, the line writeback engine,
// main memory and the cache data RAM.
interface cache_miss_ctrl_if #(
    parameter int INDEX_W = 6,
    parameter int MEM_AW  = 13,
    parameter int CNT_W   = 16
);
    // Handshake: cpu_req rises with cpu_addr/cpu_we stable and holds them until cpu_ready
    // pulses for one cycle. A new request is sampled only in IDLE, so a request held high
    // across cpu_ready is taken as the next access one cycle later.
    logic                   cpu_req;
    logic                   cpu_we;
    logic [31:0]            cpu_addr;
    logic                   cpu_ready;
    logic                   wb_start;
    logic [31:0]            wb_addr;
    logic                   wb_done;
    logic                   wb_owns_ports;
    logic [MEM_AW-1:0]      mem_raddr;
    logic [31:0]            mem_rdata;
    logic                   fill_we;
    logic [INDEX_W+2:0]     fill_addr;
    logic [31:0]            fill_data;
    logic [CNT_W-1:0]       miss_cnt;
    logic [CNT_W-1:0]       wb_cnt;
    logic [2:0]             state_dbg;

    modport master (
        output cpu_req, cpu_we, cpu_addr, wb_done, mem_rdata,
        input  cpu_ready, wb_start, wb_addr, wb_owns_ports, mem_raddr,
               fill_we, fill_addr, fill_data, miss_cnt, wb_cnt, state_dbg
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, wb_done, mem_rdata,
        output cpu_ready, wb_start, wb_addr, wb_owns_ports, mem_raddr,
               fill_we, fill_addr, fill_data, miss_cnt, wb_cnt, state_dbg
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Hit/miss sequencer for the direct-mapped write-back D-cache: tag/valid/dirty store,
// dirty-victim writeback hand-off, 8-word line refill and saturating miss/writeback counters.
module cache_miss_ctrl #(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 3,
    parameter int TAG_W    = 21,
    parameter int MEM_AW   = 13,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    cache_miss_ctrl_if.slave bus
);
    localparam int LINES    = 1 << INDEX_W;
    localparam int LINE_LSB = OFFSET_W + 2;
    localparam int LINE_W   = 32 - LINE_LSB;
    localparam int CNT_BITS = OFFSET_W + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_WB_START = 3'd2,
        S_WB_WAIT  = 3'd3,
        S_REFILL   = 3'd4,
        S_UPDATE   = 3'd5,
        S_RESPOND  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   req_line_q, req_line_d;
    logic                req_we_q, req_we_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [31:0]         wb_addr_q, wb_addr_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]    wb_cnt_q, wb_cnt_d;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_W-1:0]    tag_q [LINES];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic                line_update;
    logic                line_mark_dirty;
    logic                refill_rd;
    logic                refill_wr;
    logic [OFFSET_W-1:0] fill_beat;
    logic                unused_addr_bits;

    assign idx     = req_line_q[INDEX_W-1:0];
    assign req_tag = req_line_q[LINE_W-1:INDEX_W];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

    // Byte offset within the line never affects control.
    assign unused_addr_bits = ^bus.cpu_addr[LINE_LSB-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d         = state_q;
        req_line_d      = req_line_q;
        req_we_d        = req_we_q;
        cnt_d           = cnt_q;
        wb_addr_d       = wb_addr_q;
        miss_cnt_d      = miss_cnt_q;
        wb_cnt_d        = wb_cnt_q;
        line_update     = 1'b0;
        line_mark_dirty = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    req_line_d = bus.cpu_addr[31:LINE_LSB];
                    req_we_d   = bus.cpu_we;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    state_d = S_RESPOND;
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    if (dirty_q[idx]) begin
                        // Victim address is captured here so it is valid for the whole WB_START cycle.
                        wb_addr_d = {tag_q[idx], idx, {LINE_LSB{1'b0}}};
                        state_d   = S_WB_START;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_WB_START: begin
                wb_cnt_d = sat_inc(wb_cnt_q);
                state_d  = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (bus.wb_done) begin
                    cnt_d   = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                cnt_d = cnt_q + CNT_BITS'(1);
                if (cnt_q[OFFSET_W]) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                line_update = 1'b1;
                state_d     = S_RESPOND;
            end
            S_RESPOND: begin
                line_mark_dirty = req_we_q;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_line_q <= '0;
            req_we_q   <= 1'b0;
            cnt_q      <= '0;
            wb_addr_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_line_q <= req_line_d;
            req_we_q   <= req_we_d;
            cnt_q      <= cnt_d;
            wb_addr_q  <= wb_addr_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    // Line becomes valid only in UPDATE, so a reset mid-refill leaves it invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (line_update) begin
                tag_q[idx]   <= req_tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (line_mark_dirty) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Refill reads lead the data RAM writes by one beat to cover the synchronous memory read.
    assign refill_rd = (state_q == S_REFILL) && !cnt_q[OFFSET_W];
    assign refill_wr = (state_q == S_REFILL) && (cnt_q != '0);
    assign fill_beat = OFFSET_W'(cnt_q - CNT_BITS'(1));

    assign bus.cpu_ready     = (state_q == S_RESPOND);
    assign bus.wb_start      = (state_q == S_WB_START);
    assign bus.wb_owns_ports = (state_q == S_WB_START) || (state_q == S_WB_WAIT);
    assign bus.wb_addr       = wb_addr_q;
    assign bus.mem_raddr     = refill_rd ? {req_line_q[MEM_AW-OFFSET_W-1:0], cnt_q[OFFSET_W-1:0]} : '0;
    assign bus.fill_we       = refill_wr;
    assign bus.fill_addr     = refill_wr ? {idx, fill_beat} : '0;
    assign bus.fill_data     = bus.mem_rdata;
    assign bus.miss_cnt      = miss_cnt_q;
    assign bus.wb_cnt        = wb_cnt_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: table of accesses with hand-computed latency, refill and
// counter expectations, plus hand-written reset-during-refill and saturation checks.
module tb_cache_miss_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.INDEX_W(6), .MEM_AW(13), .CNT_W(16)) bus ();
  cache_miss_ctrl_if #(.INDEX_W(6), .MEM_AW(13), .CNT_W(2))  bus_s ();

  cache_miss_ctrl #(.INDEX_W(6), .OFFSET_W(3), .TAG_W(21), .MEM_AW(13), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Narrow-counter twin fed the same stimulus, so saturation shows after three events.
  cache_miss_ctrl #(.INDEX_W(6), .OFFSET_W(3), .TAG_W(21), .MEM_AW(13), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  assign bus_s.cpu_req   = bus.cpu_req;
  assign bus_s.cpu_we    = bus.cpu_we;
  assign bus_s.cpu_addr  = bus.cpu_addr;
  assign bus_s.wb_done   = bus.wb_done;
  assign bus_s.mem_rdata = bus.mem_rdata;

  function automatic logic [31:0] mem_fn(input logic [12:0] a);
    return {16'hC0DE, 3'b000, a};
  endfunction

  // Main memory: one-cycle synchronous read.
  always @(posedge clk) bus.mem_rdata <= mem_fn(bus.mem_raddr);

  typedef struct {
    logic        we;
    logic [31:0] addr;
    int          kind;      // 0 hit, 1 clean miss, 2 dirty miss
    int          wb_dur;    // WB_START to wb_done inclusive
    logic [31:0] exp_wb_addr;
    logic [12:0] exp_base;
    logic [8:0]  exp_fill_base;
    logic [15:0] exp_miss;
    logic [15:0] exp_wb;
    logic [1:0]  exp_smiss;
    logic [1:0]  exp_swb;
    logic        chain;     // keep cpu_req high into the next row
    logic        stray;     // pulse wb_done during refill
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [15];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input int kind, input int dur,
                              input logic [31:0] wba, input logic [12:0] base, input logic [8:0] fb,
                              input logic [15:0] m, input logic [15:0] w, input logic [1:0] sm,
                              input logic [1:0] sw, input logic ch, input logic st);
    vec_t v;
    v.we = we; v.addr = addr; v.kind = kind; v.wb_dur = dur; v.exp_wb_addr = wba;
    v.exp_base = base; v.exp_fill_base = fb; v.exp_miss = m; v.exp_wb = w;
    v.exp_smiss = sm; v.exp_swb = sw; v.chain = ch; v.stray = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_ready"}, 32'(bus.cpu_ready), 32'd0);
    check({tag, "_wb_start"}, 32'(bus.wb_start), 32'd0);
    check({tag, "_wb_addr"}, bus.wb_addr, 32'd0);
    check({tag, "_wb_owns"}, 32'(bus.wb_owns_ports), 32'd0);
    check({tag, "_mem_raddr"}, 32'(bus.mem_raddr), 32'd0);
    check({tag, "_fill_we"}, 32'(bus.fill_we), 32'd0);
    check({tag, "_fill_addr"}, 32'(bus.fill_addr), 32'd0);
    check({tag, "_miss_cnt"}, 32'(bus.miss_cnt), 32'd0);
    check({tag, "_wb_cnt"}, 32'(bus.wb_cnt), 32'd0);
  endtask

  // Starts at a negedge. chained_in: previous row left cpu_req high, we are in its RESPOND cycle.
  task automatic run_vec(input int id, input vec_t v, input logic chained_in);
    int cyc, lat, fills, starts, owns, bad, wbs_cyc, exp_lat;
    logic [12:0] prev_raddr, ra;
    logic [8:0] fa;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = v.we;
    bus.cpu_addr = v.addr;
    lat = -1; fills = 0; starts = 0; owns = 0; bad = 0; wbs_cyc = -1; prev_raddr = '0;
    cyc = chained_in ? 0 : 1;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      @(negedge clk);
      bus.wb_done = 1'b0;
      if (bus.cpu_ready) lat = cyc;
      if (bus.wb_start) begin starts++; wbs_cyc = cyc; end
      if (bus.wb_owns_ports) begin
        owns++;
        if (bus.wb_addr !== v.exp_wb_addr) bad++;
      end
      if (bus.fill_we) begin
        ra = v.exp_base + 13'(fills);
        fa = v.exp_fill_base + 9'(fills);
        if (fills > 7 || bus.fill_addr !== fa || bus.fill_data !== mem_fn(ra) || prev_raddr !== ra) bad++;
        fills++;
      end
      prev_raddr = bus.mem_raddr;
      if (wbs_cyc >= 0 && cyc == wbs_cyc + v.wb_dur - 1) bus.wb_done = 1'b1;
      if (v.stray && cyc == 4) bus.wb_done = 1'b1;
      cyc++;
    end
    bus.wb_done = 1'b0;
    exp_lat = (v.kind == 0) ? 2 : (v.kind == 1) ? 12 : 12 + v.wb_dur;
    check($sformatf("v%0d_latency", id), 32'(lat), 32'(exp_lat));
    check($sformatf("v%0d_fill_beats", id), 32'(fills), (v.kind == 0) ? 32'd0 : 32'd8);
    check($sformatf("v%0d_wb_start_pulses", id), 32'(starts), (v.kind == 2) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_wb_owns_cycles", id), 32'(owns), (v.kind == 2) ? 32'(v.wb_dur) : 32'd0);
    check($sformatf("v%0d_beat_errors", id), 32'(bad), 32'd0);
    check($sformatf("v%0d_miss_cnt", id), 32'(bus.miss_cnt), 32'(v.exp_miss));
    check($sformatf("v%0d_wb_cnt", id), 32'(bus.wb_cnt), 32'(v.exp_wb));
    check($sformatf("v%0d_sat_miss_cnt", id), 32'(bus_s.miss_cnt), 32'(v.exp_smiss));
    check($sformatf("v%0d_sat_wb_cnt", id), 32'(bus_s.wb_cnt), 32'(v.exp_swb));
    if (!v.chain) begin
      bus.cpu_req = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_idle_no_ready", id), 32'(bus.cpu_ready), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic found;
    //           we    addr           kind dur wb_addr        base      fbase miss wb sm sw ch st
    vecs[0]  = mk(1'b0, 32'h0000_0040, 1, 0, 32'h0,          13'h010,  9'd16,  1, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1'b0, 32'h0000_0040, 0, 0, 32'h0,          13'h000,  9'd0,   1, 0, 1, 0, 0, 0);
    vecs[2]  = mk(1'b1, 32'h0000_0044, 0, 0, 32'h0,          13'h000,  9'd0,   1, 0, 1, 0, 0, 0);
    vecs[3]  = mk(1'b0, 32'h0000_0840, 2, 3, 32'h0000_0040,  13'h210,  9'd16,  2, 1, 2, 1, 0, 0);
    vecs[4]  = mk(1'b0, 32'h0000_0840, 0, 0, 32'h0,          13'h000,  9'd0,   2, 1, 2, 1, 0, 0);
    vecs[5]  = mk(1'b0, 32'h0000_0040, 1, 0, 32'h0,          13'h010,  9'd16,  3, 1, 3, 1, 0, 1);
    vecs[6]  = mk(1'b1, 32'h0000_07E0, 1, 0, 32'h0,          13'h1F8,  9'd504, 4, 1, 3, 1, 0, 0);
    vecs[7]  = mk(1'b0, 32'hFFFF_FFE0, 2, 5, 32'h0000_07E0,  13'h1FF8, 9'd504, 5, 2, 3, 2, 0, 0);
    vecs[8]  = mk(1'b0, 32'hFFFF_FFFC, 0, 0, 32'h0,          13'h000,  9'd0,   5, 2, 3, 2, 0, 0);
    vecs[9]  = mk(1'b1, 32'hFFFF_FFE4, 0, 0, 32'h0,          13'h000,  9'd0,   5, 2, 3, 2, 0, 0);
    vecs[10] = mk(1'b1, 32'h0000_07E0, 2, 2, 32'hFFFF_FFE0,  13'h1F8,  9'd504, 6, 3, 3, 3, 0, 0);
    vecs[11] = mk(1'b0, 32'h0000_07E0, 0, 0, 32'h0,          13'h000,  9'd0,   6, 3, 3, 3, 0, 0);
    vecs[12] = mk(1'b1, 32'h0000_0840, 1, 0, 32'h0,          13'h210,  9'd16,  7, 3, 3, 3, 1, 0);
    vecs[13] = mk(1'b0, 32'h0000_0040, 2, 4, 32'h0000_0840,  13'h010,  9'd16,  8, 4, 3, 3, 1, 0);
    vecs[14] = mk(1'b0, 32'h0000_0044, 0, 0, 32'h0,          13'h000,  9'd0,   8, 4, 3, 3, 0, 0);

    // Clock/reset
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.wb_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_fill_data", bus.fill_data, 32'hC0DE_0000);

    for (int i = 0; i < 15; i++) begin
      run_vec(i, vecs[i], (i > 0) ? vecs[i-1].chain : 1'b0);
    end

    // Reset while refilling idx 1, at cnt=4 (writing beat 3, fill_addr 11).
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1000_0020;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (bus.fill_we && bus.fill_addr == 9'd11) found = 1'b1;
    end
    check("midreset_reached_cnt4", 32'(found), 32'd1);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    check("midreset_sat_miss_cnt", 32'(bus_s.miss_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle_ready", 32'(bus.cpu_ready), 32'd0);
    run_vec(20, mk(1'b0, 32'h0000_0040, 1, 0, 32'h0, 13'h010, 9'd16, 1, 0, 1, 0, 0, 0), 1'b0);
    run_vec(21, mk(1'b0, 32'h1000_0020, 1, 0, 32'h0, 13'h001 << 3, 9'd8, 2, 0, 2, 0, 0, 0), 1'b0);
    run_vec(22, mk(1'b0, 32'h1000_0020, 0, 0, 32'h0, 13'h000, 9'd0, 2, 0, 2, 0, 0, 0), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
